// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store handshake between the datapath (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    logic        re;        // load request
    logic        we;        // store request
    logic [31:0] addr;      // byte address
    logic [31:0] din;       // store data
    logic [31:0] dout;      // load data
    logic        stall;     // access not complete, datapath holds
    logic        wb_empty;  // write buffer has no pending entries

    modport master (
        output re, we, addr, din,
        input  dout, stall, wb_empty
    );

    modport slave (
        input  re, we, addr, din,
        output dout, stall, wb_empty
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind the datapath load/store port.
// Stores are posted into a circular write buffer that drains one entry per
// cycle into a word-addressed array; loads see a fixed READ_LAT array latency.
//
// Optional feature, enabled by defining DMEM_FWD_EN:
//   loads that match a buffered store are forwarded combinationally from the
//   newest matching entry; miss loads start at once and take array priority
//   over the drain. Without it, a load waits in IDLE (stalled) until the
//   buffer is empty and then reads the array.
module dmem_responder #(
    parameter int DEPTH    = 256,  // array words, power of two
    parameter int WB_DEPTH = 4,    // write-buffer entries, power of two, >= 2
    parameter int READ_LAT = 2     // cycles from load acceptance to data, >= 1
) (
    input  logic            clk,
    input  logic            reset,  // asynchronous, active-low
    dmem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(READ_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_e;

    typedef logic [AW-1:0] idx_t;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;    // 0..WB_DEPTH inclusive
    typedef logic [CW-1:0] lat_t;

    localparam lat_t LAT_INIT = lat_t'(READ_LAT - 1);
    localparam cnt_t CNT_FULL = cnt_t'(WB_DEPTH);

    // Control state
    state_e      state_q, state_d;
    lat_t        lat_q, lat_d;
    idx_t        rd_idx_q, rd_idx_d;
    logic [31:0] dout_q, dout_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    logic        wb_empty_q, wb_empty_d;

    // Storage
    logic [31:0] mem_q     [DEPTH];
    idx_t        wb_idx_q  [WB_DEPTH];
    logic [31:0] wb_data_q [WB_DEPTH];

    // Per-cycle decisions
    idx_t        req_idx;
    logic        full;
    logic        hit;
    logic [31:0] hit_data;
    logic        start_ok;
    logic        load_start;
    logic        enq;
    logic        deq;

    // Only the word-index bits of the address select a word; the rest wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

    assign req_idx = bus.addr[AW+1:2];
    assign full    = (count_q == CNT_FULL);

`ifdef DMEM_FWD_EN
    // Forwarding search: scan valid entries oldest to newest so the newest
    // matching store wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the loop can leave it unassigned and infer a latch.
        hit      = 1'b0;
        hit_data = '0;
        if (state_q == IDLE && bus.re) begin
            for (int k = 0; k < WB_DEPTH; k++) begin
                if (cnt_t'(k) < count_q &&
                    wb_idx_q[rd_ptr_q + ptr_t'(k)] == req_idx) begin
                    hit      = 1'b1;
                    hit_data = wb_data_q[rd_ptr_q + ptr_t'(k)];
                end
            end
        end
    end

    // A load with no buffered match is safe to read from the array right away.
    assign start_ok = 1'b1;
`else
    // Without forwarding there is never a buffer hit.
    assign hit      = 1'b0;
    assign hit_data = '0;

    // The array is only coherent for a load once every posted store landed.
    assign start_ok = (count_q == '0);
`endif

    // Handshake decisions for this cycle; a combined re/we request is a load.
    assign load_start = (state_q == IDLE) && bus.re && !hit && start_ok;
    assign enq        = bus.we && !bus.re && !full;
    assign deq        = (count_q != '0)
                      && (state_q == IDLE || state_q == RD_DONE)
                      && !load_start;

    // Datapath-facing outputs: forwarded data bypasses the read register.
    assign bus.dout     = hit ? hit_data : dout_q;
    assign bus.stall    = (bus.re && !(hit || state_q == RD_DONE))
                        || (bus.we && !bus.re && full);
    assign bus.wb_empty = wb_empty_q;

    // Read FSM next state: start, count down the array latency, present data.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        rd_idx_d = rd_idx_q;
        dout_d   = dout_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    rd_idx_d = req_idx;
                    lat_d    = LAT_INIT;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    dout_d  = mem_q[rd_idx_q];
                    state_d = RD_DONE;
                end else begin
                    lat_d = lat_q - lat_t'(1);
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-buffer bookkeeping: pointers advance independently, count nets out.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + cnt_t'(1);
        end else if (deq && !enq) begin
            count_d = count_q - cnt_t'(1);
        end
        wb_empty_d = (count_d == '0);
    end

    // Control registers: FSM, latency counter, read data and buffer pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            rd_idx_q   <= '0;
            dout_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_empty_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the pre-edge value of every other flop.
            state_q    <= state_d;
            lat_q      <= lat_d;
            rd_idx_q   <= rd_idx_d;
            dout_q     <= dout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_empty_q <= wb_empty_d;
        end
    end

    // Buffer payload capture on enqueue.
    // NOTE: payload and array storage carry no reset; clearing the pointers
    // and count is enough to discard entries, and the array keeps its data.
    always_ff @(posedge clk) begin
        if (enq) begin
            wb_idx_q[wr_ptr_q]  <= req_idx;
            wb_data_q[wr_ptr_q] <= bus.din;
        end
    end

    // Background drain of the oldest buffered store into the array.
    always_ff @(posedge clk) begin
        if (deq) begin
            mem_q[wb_idx_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
        end
    end

endmodule
